// File: rtl/gpio_irq.sv
// gpio_irq: bus-mapped GPIO with per-pin direction, atomic set/clear/toggle writes,
// input synchroniser and edge-capture interrupt status with a single level irq.
module gpio_irq #(
    parameter int CH          = 16,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    input  logic [CH-1:0]     pad_in,
    output logic [CH-1:0]     pad_out,
    output logic [CH-1:0]     pad_oe,
    output logic              irq
);

    localparam int A_IN      = 0;
    localparam int A_OUT     = 1;
    localparam int A_OUT_SET = 2;
    localparam int A_OUT_CLR = 3;
    localparam int A_OUT_TGL = 4;
    localparam int A_DIR     = 5;
    localparam int A_IE      = 6;
    localparam int A_RISE    = 7;
    localparam int A_FALL    = 8;
    localparam int A_STAT    = 9;

    logic              access;
    logic              wr_en;
    logic              rd_en;
    logic [CH-1:0]     wd;
    logic              unused_wr;

    logic [CH-1:0]     sync_q [SYNC_STAGES];
    logic [CH-1:0]     prev_q;
    logic [CH-1:0]     sync_w;
    logic [CH-1:0]     rise_w;
    logic [CH-1:0]     fall_w;

    logic [CH-1:0]     out_q,  out_d;
    logic [CH-1:0]     dir_q,  dir_d;
    logic [CH-1:0]     ie_q,   ie_d;
    logic [CH-1:0]     rise_q, rise_d;
    logic [CH-1:0]     fall_q, fall_d;
    logic [CH-1:0]     stat_q, stat_d;
    logic [CH-1:0]     w1c_mask;

    logic [CH-1:0]     rd_bits;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rdy_q;
    logic              irq_q;

    assign access    = !cs_ && !as_;
    assign wr_en     = access && !rw;
    assign rd_en     = access && rw;
    assign wd        = wr_data[CH-1:0];
    assign unused_wr = ^wr_data;

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign rise_w = sync_w & ~prev_q;
    assign fall_w = ~sync_w & prev_q;

    // Input synchroniser plus one extra register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this flop array is reset element by element; it is real state, not a RAM.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples its pre-edge neighbour.
            sync_q[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_w;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        out_d    = out_q;
        dir_d    = dir_q;
        ie_d     = ie_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        w1c_mask = '0;
        if (wr_en) begin
            case (addr)
                ADDR_W'(A_OUT):     out_d    = wd;
                ADDR_W'(A_OUT_SET): out_d    = out_q | wd;
                ADDR_W'(A_OUT_CLR): out_d    = out_q & ~wd;
                ADDR_W'(A_OUT_TGL): out_d    = out_q ^ wd;
                ADDR_W'(A_DIR):     dir_d    = wd;
                ADDR_W'(A_IE):      ie_d     = wd;
                ADDR_W'(A_RISE):    rise_d   = wd;
                ADDR_W'(A_FALL):    fall_d   = wd;
                ADDR_W'(A_STAT):    w1c_mask = wd;
                default:            ;
            endcase
        end
        // New edges are OR-ed in after the clear, so a same-cycle set beats W1C.
        stat_d = (stat_q & ~w1c_mask) | (rise_w & rise_q) | (fall_w & fall_q);
    end

    always_comb begin
        rd_bits   = '0;
        rd_data_d = '0;
        case (addr)
            ADDR_W'(A_IN):   rd_bits = sync_w;
            ADDR_W'(A_OUT):  rd_bits = out_q;
            ADDR_W'(A_DIR):  rd_bits = dir_q;
            ADDR_W'(A_IE):   rd_bits = ie_q;
            ADDR_W'(A_RISE): rd_bits = rise_q;
            ADDR_W'(A_FALL): rd_bits = fall_q;
            ADDR_W'(A_STAT): rd_bits = stat_q;
            default:         rd_bits = '0;
        endcase
        if (rd_en) rd_data_d[CH-1:0] = rd_bits;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            ie_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            stat_q    <= '0;
            rd_data_q <= '0;
            rdy_q     <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            ie_q      <= ie_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            stat_q    <= stat_d;
            rd_data_q <= rd_data_d;
            rdy_q     <= !access;
            irq_q     <= |(stat_q & ie_q);
        end
    end

    assign rd_data = rd_data_q;
    assign rdy_    = rdy_q;
    assign irq     = irq_q;
    assign pad_out = out_q;
    assign pad_oe  = dir_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Scoreboard bench for gpio_irq: bus tasks push expected read data, a negedge
// monitor pops and compares whenever rdy_ is low.
module tb_gpio_irq;

    localparam int CH = 16;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_;
    logic          as_;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rdy_;
    logic [CH-1:0] pad_in;
    logic [CH-1:0] pad_out;
    logic [CH-1:0] pad_oe;
    logic          irq;

    int            checks   = 0;
    int            failures = 0;
    logic          mon_en   = 1'b0;
    logic [DW-1:0] exp_q [$];

    gpio_irq #(.CH(CH), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .pad_in(pad_in),
        .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed access must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rdy_ === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdy", {31'b0, rdy_}, 32'h1);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end else begin
                check("rd_data_idle", rd_data, '0);
            end
        end
    end

    // Bus tasks are entered and left at posedge+1; consecutive calls are back-to-back.
    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = a; wr_data = d;
        exp_q.push_back('0);
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a; wr_data = '0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] a);
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = a; reset = 1'b1;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1; reset = 1'b0;
        check("rst_rdy", {31'b0, rdy_}, 32'h1);
        check("rst_rd_data", rd_data, '0);
        check("rst_pad_out", {16'b0, pad_out}, '0);
        check("rst_pad_oe", {16'b0, pad_oe}, '0);
        check("rst_irq", {31'b0, irq}, '0);
    endtask

    initial begin
        reset = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0; pad_in = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        idle(2);
        reset = 1'b0;
        check("reset_rdy", {31'b0, rdy_}, 32'h1);
        check("reset_irq", {31'b0, irq}, '0);
        check("reset_pad_oe", {16'b0, pad_oe}, '0);
        check("reset_pad_out", {16'b0, pad_out}, '0);

        // Every address reads zero after reset, back-to-back.
        for (int a = 0; a < 16; a++) bus_read(AW'(a), '0);
        check("map_pad_oe", {16'b0, pad_oe}, '0);
        check("map_irq", {31'b0, irq}, '0);

        // Output register and atomic updates; upper wr_data bits ignored.
        bus_write(4'd5, 32'h0000_00FF);
        bus_write(4'd1, 32'hDEAD_1234);
        bus_write(4'd2, 32'h0000_0F00);
        bus_write(4'd3, 32'h0000_0004);
        bus_write(4'd4, 32'h0000_8001);
        check("pad_out", {16'b0, pad_out}, 32'h0000_9F31);
        check("pad_oe", {16'b0, pad_oe}, 32'h0000_00FF);
        bus_read(4'd1, 32'h0000_9F31);
        bus_read(4'd2, 32'h0);
        bus_read(4'd5, 32'h0000_00FF);
        bus_write(4'd12, 32'hFFFF_FFFF);
        bus_read(4'd12, 32'h0);
        check("pad_out_after_unmapped", {16'b0, pad_out}, 32'h0000_9F31);

        // Synchroniser latency on IN.
        pad_in = 16'hA5A5;
        bus_read(4'd0, 32'h0);
        idle(1);
        bus_read(4'd0, 32'h0000_A5A5);

        // Edge capture and interrupt.
        pad_in = 16'h0002;
        idle(4);
        bus_write(4'd7, 32'h1);
        bus_write(4'd8, 32'h2);
        bus_write(4'd6, 32'h3);
        pad_in = 16'h0001;
        idle(2);
        bus_read(4'd9, 32'h0);
        check("irq_before_stat", {31'b0, irq}, '0);
        bus_read(4'd9, 32'h3);
        check("irq_after_stat", {31'b0, irq}, 32'h1);
        bus_write(4'd9, 32'h1);
        bus_read(4'd9, 32'h2);
        check("irq_partial_clear", {31'b0, irq}, 32'h1);
        bus_write(4'd9, 32'h2);
        check("irq_clear_latency", {31'b0, irq}, 32'h1);
        idle(1);
        check("irq_cleared", {31'b0, irq}, '0);
        bus_read(4'd9, 32'h0);

        // Set wins over a same-cycle W1C; IE only gates irq.
        bus_write(4'd6, 32'h0);
        pad_in = 16'h0000;
        idle(4);
        pad_in = 16'h0001;
        idle(2);
        bus_write(4'd9, 32'h1);
        bus_read(4'd9, 32'h1);
        check("irq_masked", {31'b0, irq}, '0);
        bus_write(4'd6, 32'h1);
        check("irq_enable_latency", {31'b0, irq}, '0);
        idle(1);
        check("irq_enabled", {31'b0, irq}, 32'h1);

        // Reset in the middle of a read.
        pad_in = 16'h0000;
        reset_mid_read(4'd1);
        idle(2);

        // Reset with outputs driven and status pending.
        bus_write(4'd5, 32'h0000_FFFF);
        bus_write(4'd1, 32'h0000_FFFF);
        bus_write(4'd7, 32'h0000_00FF);
        bus_write(4'd6, 32'h0000_00FF);
        idle(4);
        pad_in = 16'h00FF;
        idle(4);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        check("pre_rst_pad_out", {16'b0, pad_out}, 32'h0000_FFFF);
        bus_read(4'd9, 32'h0000_00FF);
        reset_mid_read(4'd9);
        idle(4);
        bus_read(4'd9, 32'h0);
        check("post_rst_irq", {31'b0, irq}, '0);

        idle(3);
        check("scoreboard_empty", exp_q.size(), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
